// File: rtl/alu_ctrl_stage.sv
// ALU control stage: decodes ALUOp/funct into the EX-stage ALU operation code
// and buffers decoded entries in a 2-entry registered skid buffer with flush.
module alu_ctrl_stage #(
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned OP_W    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [1:0]         alu_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [OP_W-1:0]    alu_operation_o,
  output logic               ovf_en_o,
  output logic               illegal_o
);

  localparam logic [OP_W-1:0] OP_AND = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(4'b0111);
  localparam logic [OP_W-1:0] OP_NOR = OP_W'(4'b1100);

  localparam logic [FUNCT_W-1:0] FN_ADD  = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_ADDU = FUNCT_W'(6'b100001);
  localparam logic [FUNCT_W-1:0] FN_SUB  = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_SUBU = FUNCT_W'(6'b100011);
  localparam logic [FUNCT_W-1:0] FN_AND  = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR   = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_NOR  = FUNCT_W'(6'b100111);
  localparam logic [FUNCT_W-1:0] FN_SLT  = FUNCT_W'(6'b101010);

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic            ovf_en;
    logic            illegal;
  } entry_t;

  entry_t dec_c;
  entry_t out_q;
  entry_t skid_q;
  logic   out_valid_q;
  logic   skid_valid_q;
  logic   in_ready_q;
  logic   accept_c;
  logic   drain_c;

  // Input-side decode of ALUOp and funct.
  always_comb begin
    dec_c = '{op: OP_ADD, ovf_en: 1'b0, illegal: 1'b0};
    unique case (alu_op_i)
      2'b00: dec_c = '{op: OP_ADD, ovf_en: 1'b1, illegal: 1'b0};
      2'b01: dec_c = '{op: OP_SUB, ovf_en: 1'b0, illegal: 1'b0};
      2'b11: dec_c = '{op: OP_SLT, ovf_en: 1'b0, illegal: 1'b0};
      default: begin
        unique case (funct_i)
          FN_ADD:  dec_c = '{op: OP_ADD, ovf_en: 1'b1, illegal: 1'b0};
          FN_ADDU: dec_c = '{op: OP_ADD, ovf_en: 1'b0, illegal: 1'b0};
          FN_SUB:  dec_c = '{op: OP_SUB, ovf_en: 1'b1, illegal: 1'b0};
          FN_SUBU: dec_c = '{op: OP_SUB, ovf_en: 1'b0, illegal: 1'b0};
          FN_AND:  dec_c = '{op: OP_AND, ovf_en: 1'b0, illegal: 1'b0};
          FN_OR:   dec_c = '{op: OP_OR,  ovf_en: 1'b0, illegal: 1'b0};
          FN_NOR:  dec_c = '{op: OP_NOR, ovf_en: 1'b0, illegal: 1'b0};
          FN_SLT:  dec_c = '{op: OP_SLT, ovf_en: 1'b0, illegal: 1'b0};
          default: dec_c = '{op: OP_ADD, ovf_en: 1'b0, illegal: 1'b1};
        endcase
      end
    endcase
  end

  assign accept_c = in_valid_i && in_ready_q;
  assign drain_c  = out_valid_q && out_ready_i;

  // Skid buffer: OUT always holds the oldest entry, SKID the younger one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (!out_valid_q || drain_c) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= accept_c;
        in_ready_q   <= !accept_c;
        if (accept_c) begin
          skid_q <= dec_c;
        end
      end else begin
        out_valid_q <= accept_c;
        if (accept_c) begin
          out_q <= dec_c;
        end
      end
    end else if (accept_c) begin
      skid_q       <= dec_c;
      skid_valid_q <= 1'b1;
      in_ready_q   <= 1'b0;
    end
  end

  assign in_ready_o      = in_ready_q;
  assign out_valid_o     = out_valid_q;
  assign alu_operation_o = out_q.op;
  assign ovf_en_o        = out_q.ovf_en;
  assign illegal_o       = out_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: decode table, skid back-pressure, flush, reset.
module tb_alu_ctrl_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] alu_op = 2'b00;
  logic [5:0] funct = 6'b000000;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] alu_operation;
  logic       ovf_en;
  logic       illegal;

  int errors = 0;
  int checks = 0;

  // {alu_op, funct, op, ovf_en, illegal}
  typedef struct packed {
    logic [1:0] aop;
    logic [5:0] fn;
    logic [3:0] op;
    logic       ovf;
    logic       ill;
  } vec_t;

  vec_t vecs [12];

  alu_ctrl_stage #(.FUNCT_W(6), .OP_W(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .alu_op_i        (alu_op),
    .funct_i         (funct),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .alu_operation_o (alu_operation),
    .ovf_en_o        (ovf_en),
    .illegal_o       (illegal)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_two_stalled();
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = 2'b00; funct = 6'b000000;
    step();
    alu_op = 2'b01;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_operation !== 4'b0000 ||
        ovf_en !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b op=%b ovf=%b ill=%b, want 0 1 0000 0 0",
               out_valid, in_ready, alu_operation, ovf_en, illegal);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 1'b1; alu_op = 2'b10; funct = 6'b101010;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_operation !== 4'b0111 || ovf_en !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL single: valid=%b op=%b ovf=%b ill=%b, want 1 0111 0 0",
               out_valid, alu_operation, ovf_en, illegal);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_decode_sweep();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; alu_op = vecs[i].aop; funct = vecs[i].fn;
      step();
      checks++;
      if (out_valid !== 1'b1 || alu_operation !== vecs[i].op ||
          ovf_en !== vecs[i].ovf || illegal !== vecs[i].ill) begin
        errors++;
        $display("FAIL decode[%0d]: valid=%b op=%b ovf=%b ill=%b, want 1 %b %b %b",
                 i, out_valid, alu_operation, ovf_en, illegal, vecs[i].op, vecs[i].ovf, vecs[i].ill);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = 2'b00; funct = 6'b000000;
    step();
    checks++;
    if (out_valid !== 1'b1 || alu_operation !== 4'b0010 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_a: valid=%b op=%b ready=%b, want 1 0010 1", out_valid, alu_operation, in_ready);
    end
    alu_op = 2'b01;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || alu_operation !== 4'b0010 || ovf_en !== 1'b1) begin
      errors++;
      $display("FAIL bp_b: ready=%b op=%b ovf=%b, want 0 0010 1", in_ready, alu_operation, ovf_en);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_operation !== 4'b0010) begin
      errors++;
      $display("FAIL bp_hold: valid=%b ready=%b op=%b, want 1 0 0010", out_valid, in_ready, alu_operation);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || alu_operation !== 4'b0110 || ovf_en !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b op=%b ovf=%b ready=%b, want 1 0110 0 1",
               out_valid, alu_operation, ovf_en, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_empty: valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; alu_op = vecs[i + 3].aop; funct = vecs[i + 3].fn;
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || alu_operation !== vecs[i + 3].op ||
          ovf_en !== vecs[i + 3].ovf) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b ready=%b op=%b ovf=%b, want 1 1 %b %b",
                 i, out_valid, in_ready, alu_operation, ovf_en, vecs[i + 3].op, vecs[i + 3].ovf);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    push_two_stalled();
    flush = 1'b1;
    in_valid = 1'b1; alu_op = 2'b11; funct = 6'b000000;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_stale[%0d]: valid=%b op=%b, want valid 0", i, out_valid, alu_operation);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    push_two_stalled();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || alu_operation !== 4'b0000 || in_ready !== 1'b1 || ovf_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall: valid=%b op=%b ready=%b ovf=%b, want 0 0000 1 0",
               out_valid, alu_operation, in_ready, ovf_en);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_stale: valid=%b, want 0", out_valid);
    end
    push_two_stalled();
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || alu_operation !== 4'b0000 || in_ready !== 1'b1 ||
        ovf_en !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL rst_flush: valid=%b op=%b ready=%b ovf=%b ill=%b, want 0 0000 1 0 0",
               out_valid, alu_operation, in_ready, ovf_en, illegal);
    end
  endtask

  initial begin
    vecs[0]  = '{aop: 2'b00, fn: 6'b000000, op: 4'b0010, ovf: 1'b1, ill: 1'b0};
    vecs[1]  = '{aop: 2'b01, fn: 6'b000000, op: 4'b0110, ovf: 1'b0, ill: 1'b0};
    vecs[2]  = '{aop: 2'b11, fn: 6'b000000, op: 4'b0111, ovf: 1'b0, ill: 1'b0};
    vecs[3]  = '{aop: 2'b10, fn: 6'b100000, op: 4'b0010, ovf: 1'b1, ill: 1'b0};
    vecs[4]  = '{aop: 2'b10, fn: 6'b100001, op: 4'b0010, ovf: 1'b0, ill: 1'b0};
    vecs[5]  = '{aop: 2'b10, fn: 6'b100010, op: 4'b0110, ovf: 1'b1, ill: 1'b0};
    vecs[6]  = '{aop: 2'b10, fn: 6'b100011, op: 4'b0110, ovf: 1'b0, ill: 1'b0};
    vecs[7]  = '{aop: 2'b10, fn: 6'b100100, op: 4'b0000, ovf: 1'b0, ill: 1'b0};
    vecs[8]  = '{aop: 2'b10, fn: 6'b100101, op: 4'b0001, ovf: 1'b0, ill: 1'b0};
    vecs[9]  = '{aop: 2'b10, fn: 6'b100111, op: 4'b1100, ovf: 1'b0, ill: 1'b0};
    vecs[10] = '{aop: 2'b10, fn: 6'b101010, op: 4'b0111, ovf: 1'b0, ill: 1'b0};
    vecs[11] = '{aop: 2'b10, fn: 6'b100110, op: 4'b0010, ovf: 1'b0, ill: 1'b1};

    test_reset();
    test_single();
    test_decode_sweep();
    test_back_pressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- ID/EX-side producer of the 4-bit ALU operation code consumed by the EX-stage ALU. It also produces the overflow-trap enable and the illegal-op flag.
- Decodes ALUOp plus the R-type funct field into the ALU's operation encoding.
- Holds decoded entries in a 2-entry registered skid buffer with valid/ready handshakes on both sides, so EX-stage stalls never drop or duplicate an instruction.
- Supports pipeline flush for branch redirect.

Parameters:
- FUNCT_W, 6, width of the funct field.
- OP_W, 4, width of the ALU operation code.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous flush of all buffered entries.
- in_valid_i  input  1  decode-side entry valid.
- in_ready_o  output  1  stage can accept an entry this cycle.
- alu_op_i  input  2  ALUOp from the main control.
- funct_i  input  FUNCT_W  instruction funct field.
- out_valid_o  output  1  output entry valid.
- out_ready_i  input  1  EX stage consumes the output entry this cycle.
- alu_operation_o  output  OP_W  ALU operation code.
- ovf_en_o  output  1  overflow result must trap (signed add/sub only).
- illegal_o  output  1  unrecognised R-type funct.

Behaviour:
- Decode is combinational on the input side and produces {op, ovf_en, illegal}:
  - alu_op_i=00: op 0010 (add), ovf_en=1. Used for lw/sw/addi.
  - alu_op_i=01: op 0110 (sub), ovf_en=0. Used for beq compare.
  - alu_op_i=11: op 0111 (slt), ovf_en=0. Used for slti.
  - alu_op_i=10: decoded on funct_i:
    - 100000 gives 0010 with ovf_en=1.
    - 100001 gives 0010 with ovf_en=0.
    - 100010 gives 0110 with ovf_en=1.
    - 100011 gives 0110 with ovf_en=0.
    - 100100 gives 0000.
    - 100101 gives 0001.
    - 100111 gives 1100.
    - 101010 gives 0111.
    - Any other funct gives op 0010, ovf_en=0, illegal=1.
  - illegal=0 in every case except the unrecognised R-type funct.
- Storage: output register (OUT) plus one skid register (SKID). Each has a valid bit. The outputs are driven directly from OUT; there is no combinational path from the inputs to the outputs.
- in_ready_o equals the registered inverse of SKID.valid. It is never a function of out_ready_i in the same cycle.
- Accept: an entry is taken when in_valid_i && in_ready_o.
- Drain: OUT is consumed when out_valid_o && out_ready_i.
- Next-state rules, evaluated per cycle:
  - OUT empty or drained, SKID empty, accept: OUT <= new entry.
  - OUT empty or drained, SKID full: OUT <= SKID. SKID <= new entry if accepted, else SKID empties. Accept is impossible in this case because in_ready_o=0.
  - OUT full and not drained, accept: SKID <= new entry. in_ready_o goes to 0 next cycle.
  - No accept, no drain: hold all state.
- Ordering: strictly FIFO. An entry never bypasses an older one.
- Latency: 1 cycle from accept to out_valid_o when the buffer is empty.
- While out_valid_o=1 && out_ready_i=0, alu_operation_o, ovf_en_o and illegal_o must stay stable.
- Flush: on flush_i=1, both valid bits clear at the edge and out_valid_o=0 the next cycle. An entry presented in the flush cycle is discarded, even if in_ready_o=1. in_ready_o=1 the next cycle. Flush has priority over accept and drain.
- Reset: rst_i has priority over flush. Reset values are out_valid_o=0, in_ready_o=1, alu_operation_o=0000, ovf_en_o=0, illegal_o=0. Asserting reset mid-stall drops all entries.
- Payload registers need not clear on flush, but out_valid_o gates their meaning.

Test Plan:
- Reset then single entry: in_valid_i=1, alu_op_i=10, funct_i=101010 -> next cycle out_valid_o=1, alu_operation_o=0111, ovf_en_o=0, illegal_o=0.
- Full decode sweep with out_ready_i=1: each ALUOp/funct pair listed above -> matching code and ovf_en one cycle later. funct 100110 -> op 0010, illegal_o=1.
- Back-pressure:
  - Hold out_ready_i=0 and push A (add, 00), then B (beq, 01).
  - Required: in_ready_o=0 after B; output stays 0010 stable.
  - Release out_ready_i: output 0010 then 0110 on consecutive cycles, and in_ready_o returns to 1.
- Streaming with out_ready_i=1 every cycle, 8 back-to-back entries -> 8 outputs in order, one per cycle, in_ready_o never deasserts.
- Flush with both entries full and a new entry presented in the same cycle -> next cycle out_valid_o=0, in_ready_o=1, no stale entry emerges later.
- rst_i asserted while stalled with 2 entries -> next cycle out_valid_o=0, alu_operation_o=0000, in_ready_o=1. Simultaneous rst_i and flush_i -> reset values.
